seq_mult16: RTL and testbench

//   Multi-cycle 16x16 shift-and-add multiplier. Returns the low 16 bits of the product.
//   It sits directly upstream of the team's 16-bit ripple adder (adder16).
//   It instantiates one adder16, feeds it the accumulator and the shifted multiplicand,
//   and consumes its sum once per cycle.
//   It gives the ALU/CPU datapath a multiply without a combinational array.

---
 rtl/seq_mult16.sv | 126 ++++++++++++
 tb/tb_seq_mult16.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult16.sv
// Multi-cycle 16x16 shift-and-add multiplier returning the low 16 bits of a*b.
// Includes adder16, the ripple-carry adder that accumulates one partial product per cycle.

module adder16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   logic [15:0] c;

   assign c[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_fa
         assign sum[gi] = a[gi] ^ b[gi] ^ c[gi];
         // The carry out of bit 15 is dropped: sums wrap mod 2^16.
         if (gi < 15) begin : g_carry
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
         end
      end
   endgenerate
endmodule

module seq_mult16 #(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] add_sum;
   logic [WIDTH-1:0] acc_next;
   logic             last_iter;

   adder16 u_adder16 (
      .a   (acc_q),
      .b   (mcand_q),
      .sum (add_sum)
   );

   assign acc_next  = mplier_q[0] ? add_sum : acc_q;
   // Early exit once no multiplier bits remain after this iteration's shift.
   assign last_iter = (cnt_q == 4'd15) || (EARLY_EXIT && ((mplier_q >> 1) == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = RUN;
         RUN:     if (last_iter) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q == RUN);
      done    = done_q;
      product = product_q;
   end

   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
         end
      end else begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 4'd1;
         if (last_iter) begin
            product_d = acc_next;
            done_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end
endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: runs an EARLY_EXIT=1 and an EARLY_EXIT=0 instance
// side by side on shared inputs and compares both against an arithmetic reference.

module tb_seq_mult16;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy1, done1, busy0, done0;
   logic [15:0] product1, product0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mult16 #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_ee (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy1), .done(done1), .product(product1)
   );

   seq_mult16 #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_full (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy0), .done(done0), .product(product0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_product(input logic [15:0] av, input logic [15:0] bv);
      int unsigned p;
      p = int'(av) * int'(bv);
      return 16'(p % 65536);
   endfunction

   function automatic int ref_iters(input logic [15:0] bv, input bit ee);
      if (!ee) return 16;
      for (int i = 15; i >= 0; i--)
         if (bv[i]) return i + 1;
      return 1;
   endfunction

   // One operation on both instances; observes 40 cycles and checks busy length, done, product.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv);
      int bc1, bc0, dc1, dc0, dbl;
      logic [15:0] p1, p0;
      logic pd1, pd0;
      bc1 = 0; bc0 = 0; dc1 = 0; dc0 = 0; dbl = 0; p1 = '0; p0 = '0; pd1 = 0; pd0 = 0;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      for (int i = 0; i < 40; i++) begin
         if (busy1) bc1++;
         if (busy0) bc0++;
         if (done1) begin dc1++; p1 = product1; end
         if (done0) begin dc0++; p0 = product0; end
         if ((done1 && pd1) || (done0 && pd0)) dbl++;
         pd1 = done1; pd0 = done0;
         @(negedge clk);
      end
      $display("op %s a=%04h b=%04h ee1: busy=%0d prod=%04h ee0: busy=%0d prod=%04h",
               tag, av, bv, bc1, p1, bc0, p0);
      check({tag, " busy_ee1"}, bc1, ref_iters(bv, 1'b1));
      check({tag, " busy_ee0"}, bc0, ref_iters(bv, 1'b0));
      check({tag, " done_ee1"}, dc1, 1);
      check({tag, " done_ee0"}, dc0, 1);
      check({tag, " done_double"}, dbl, 0);
      check({tag, " prod_ee1"}, p1, ref_product(av, bv));
      check({tag, " prod_ee0"}, p0, ref_product(av, bv));
   endtask

   task automatic wait_done(input bit sel_ee, input string tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sel_ee ? done1 : done0) begin ok = 1'b1; break; end
      end
      check({tag, " wait_done"}, ok, 1'b1);
   endtask

   initial begin
      bit ok;
      int dc;
      logic [15:0] ra, rb;

      #12;
      check("reset busy_ee1", busy1, 1'b0);
      check("reset done_ee1", done1, 1'b0);
      check("reset product_ee1", product1, 16'h0);
      check("reset busy_ee0", busy0, 1'b0);
      check("reset product_ee0", product0, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("t1", 16'd3, 16'd5);
      run_op("t2", 16'hFFFF, 16'hFFFF);
      run_op("t3", 16'd300, 16'd300);
      run_op("t4", 16'h1234, 16'h0000);
      run_op("msb", 16'h0001, 16'h8000);

      // Start while busy is ignored; start in the done cycle is accepted.
      @(negedge clk);
      a = 16'd7; b = 16'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'd2; b = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b1, "t5a", ok);
      check("t5 ignored_prod_ee1", product1, 16'd63);
      a = 16'd2; b = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t5 b2b done_drop", done1, 1'b0);
      check("t5 b2b busy", busy1, 1'b1);
      check("t5 b2b prod_held", product1, 16'd63);
      wait_done(1'b1, "t5b", ok);
      check("t5 b2b prod_ee1", product1, 16'd4);
      wait_done(1'b0, "t5c", ok);
      check("t5 ignored_prod_ee0", product0, 16'd63);
      $display("op t5 ee1 prod=%04h ee0 prod=%04h", product1, product0);

      // Asynchronous reset mid-operation.
      @(negedge clk);
      a = 16'h1357; b = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6 rst busy_ee1", busy1, 1'b0);
      check("t6 rst done_ee1", done1, 1'b0);
      check("t6 rst prod_ee1", product1, 16'h0);
      check("t6 rst busy_ee0", busy0, 1'b0);
      check("t6 rst prod_ee0", product0, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done1 || done0 || busy1 || busy0) dc++;
      end
      check("t6 no_done_after_abort", dc, 0);
      $display("op t6 reset abort activity=%0d", dc);
      run_op("t6 restart", 16'h0102, 16'h0304);

      for (int n = 0; n < 24; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom) >> $urandom_range(0, 16);
         run_op($sformatf("rnd%0d", n), ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
